sel_arbiter: RTL

SEL_ARBITER -- requirements
Module: sel_arbiter

---
 rtl/sel_arbiter_pkg.sv | 21 ++
 rtl/sel_arbiter_cnt.sv | 29 ++
 rtl/sel_arbiter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sel_arbiter_pkg.sv
// Shared definitions for the two-source select arbiter: state encoding,
// mux select values and parameter defaults.
package sel_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2,
    GUARD = 2'd3
  } state_t;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  localparam int MAX_HOLD_DEFAULT     = 8;
  localparam int GUARD_CYCLES_DEFAULT = 1;

  // Wide enough for the largest legal hold count (MAX_HOLD up to 255).
  localparam int CNT_WIDTH = 8;

endpackage

// File: rtl/sel_arbiter_cnt.sv
// Shared hold/guard cycle counter. Clears on load, advances while enabled,
// and flags when the running count equals the supplied terminal value.
module sel_arbiter_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] term,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  // Count cycles spent in the current state; a state change restarts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (en) begin
      count <= count + WIDTH'(1);
    end
  end

  assign tc = (count == term);

endmodule

// File: rtl/sel_arbiter.sv
// Two-source grant arbiter driving the select of a downstream 2:1 mux.
// A grant lasts until the owner releases (done or request drop) or the hold
// limit is reached, followed by a guard gap with no grant.
// Optional feature: define SEL_ARBITER_ROUND_ROBIN_EN to resolve ties by
// alternating winners; otherwise source a always wins a tie.
module sel_arbiter
  import sel_arbiter_pkg::*;
#(
  parameter int MAX_HOLD     = MAX_HOLD_DEFAULT,
  parameter int GUARD_CYCLES = GUARD_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic done_a,
  input  logic done_b,
  output logic sel,
  output logic gnt_a,
  output logic gnt_b,
  output logic busy
);

  localparam logic [CNT_WIDTH-1:0] HOLD_TERM  = CNT_WIDTH'(MAX_HOLD - 1);
  localparam logic [CNT_WIDTH-1:0] GUARD_TERM = CNT_WIDTH'(GUARD_CYCLES - 1);

  state_t               state;
  state_t               state_next;
  logic                 cnt_load;
  logic                 cnt_en;
  logic [CNT_WIDTH-1:0] cnt_term;
  logic                 cnt_tc;
  logic                 tie_to_b;

  // One counter serves both the hold limit and the guard gap.
  sel_arbiter_cnt #(
    .WIDTH (CNT_WIDTH)
  ) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .en   (cnt_en),
    .term (cnt_term),
    .tc   (cnt_tc)
  );

  assign cnt_load = (state_next != state);
  assign cnt_en   = (state != IDLE);

`ifdef SEL_ARBITER_ROUND_ROBIN_EN
  logic last_b;

  // Remember who released last so the other source wins the next tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_b <= 1'b1;
    end else if (state == GNT_A && state_next == GUARD) begin
      last_b <= 1'b0;
    end else if (state == GNT_B && state_next == GUARD) begin
      last_b <= 1'b1;
    end
  end

  assign tie_to_b = ~last_b;
`else
  assign tie_to_b = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Arbitration, release and guard sequencing.
  always_comb begin
    state_next = state;
    cnt_term   = HOLD_TERM;
    case (state)
      IDLE: begin
        if (req_a && (!req_b || !tie_to_b)) begin
          state_next = GNT_A;
        end else if (req_b) begin
          state_next = GNT_B;
        end
      end
      GNT_A: begin
        if (done_a || !req_a || cnt_tc) begin
          state_next = GUARD;
        end
      end
      GNT_B: begin
        if (done_b || !req_b || cnt_tc) begin
          state_next = GUARD;
        end
      end
      GUARD: begin
        cnt_term = GUARD_TERM;
        if (cnt_tc) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Registered outputs decoded from the upcoming state; sel holds outside grants.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_a <= 1'b0;
      gnt_b <= 1'b0;
      busy  <= 1'b0;
      sel   <= SEL_A;
    end else begin
      gnt_a <= (state_next == GNT_A);
      gnt_b <= (state_next == GNT_B);
      busy  <= (state_next != IDLE);
      if (state_next == GNT_A) begin
        sel <= SEL_A;
      end else if (state_next == GNT_B) begin
        sel <= SEL_B;
      end
    end
  end

endmodule
